// File: rtl/keypad_scanner.sv
// ROWS x COLS matrix keypad scanner: row sync, column scan, debounce, key-index encode.
// Defining KEY_REPEAT_EN adds auto-repeat of KeyValid while a key stays held.
module keypad_scanner #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int CODE_W        = 4,
    parameter int DEBOUNCE      = 8,
    parameter int SCAN_DIV      = 4,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 100000
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ROWS-1:0]   Sense,
    output logic [COLS-1:0]   Drive,
    output logic              press,
    output logic              KeyValid,
    output logic [CODE_W-1:0] CodeOut,
    output logic              Multi
);
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam int DIV_W = $clog2(SCAN_DIV + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SCAN     = 3'd1;
    localparam logic [2:0] S_DEBOUNCE = 3'd2;
    localparam logic [2:0] S_HELD     = 3'd3;
    localparam logic [2:0] S_RELEASE  = 3'd4;

    // Counting to DEBOUNCE-2 here means the evaluating cycle plus this run span DEBOUNCE stable cycles
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 2);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [COLS-1:0]  COL_ONE  = COLS'(1);

    if (DEBOUNCE < 2 || SCAN_DIV < 3 || CODE_W < $clog2(ROWS * COLS) ||
        REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
        $error("keypad_scanner: parameter out of range");
    end

    logic [2:0]        state;
    logic [COL_W-1:0]  col;
    logic [DIV_W-1:0]  div;
    logic [CNT_W-1:0]  cnt;
    logic [ROWS-1:0]   sync1, s, pat, pat_low;
    logic [ROW_W-1:0]  low_row;
    logic [CODE_W-1:0] code_next;
    logic              multi_hit, rep_fire;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1 <= '1;
            s     <= '1;
        end else begin
            sync1 <= Sense;
            s     <= sync1;
        end
    end

    assign pat_low   = ~pat;
    assign multi_hit = (pat_low & (pat_low - ROWS'(1))) != '0;

    always_comb begin
        low_row = '0;
        for (int i = ROWS - 1; i >= 0; i--)
            if (!pat[i]) low_row = ROW_W'(i);
    end

    assign code_next = CODE_W'(int'(low_row) * COLS + int'(col));
    assign Drive     = (state == S_IDLE) ? '0 : ~(COL_ONE << col);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            col      <= '0;
            div      <= '0;
            cnt      <= '0;
            pat      <= '1;
            press    <= 1'b0;
            KeyValid <= 1'b0;
            CodeOut  <= '0;
            Multi    <= 1'b0;
        end else begin
            KeyValid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (s != '1) begin
                        state <= S_SCAN;
                        col   <= '0;
                        div   <= '0;
                    end
                end
                S_SCAN: begin
                    if (div != DIV_LAST) begin
                        div <= div + DIV_W'(1);
                    end else begin
                        div <= '0;
                        if (s != '1) begin
                            pat   <= s;
                            cnt   <= '0;
                            state <= S_DEBOUNCE;
                        end else if (col == COL_LAST) begin
                            state <= S_IDLE;
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (s == pat) begin
                        if (cnt == CNT_LAST) begin
                            state    <= S_HELD;
                            cnt      <= '0;
                            press    <= 1'b1;
                            KeyValid <= 1'b1;
                            CodeOut  <= code_next;
                            Multi    <= multi_hit;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        state <= S_SCAN;
                        col   <= '0;
                        div   <= '0;
                        cnt   <= '0;
                    end
                end
                S_HELD: begin
                    if (s != pat) begin
                        state <= S_RELEASE;
                        cnt   <= '0;
                    end else if (rep_fire) begin
                        KeyValid <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (s == '1) begin
                        if (cnt == CNT_LAST) begin
                            state <= S_IDLE;
                            cnt   <= '0;
                            press <= 1'b0;
                            Multi <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if (s == pat) begin
                        // Bounce back to the same key: resume holding without a new strobe
                        state <= S_HELD;
                        cnt   <= '0;
                    end else begin
                        cnt <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_armed;

    // First repeat after REPEAT_DELAY, later ones every REPEAT_PERIOD; restarts on any HELD entry
    assign rep_fire = (state == S_HELD) && (s == pat) &&
                      (rep_armed ? (rep_cnt == REP_W'(REPEAT_PERIOD - 1))
                                 : (rep_cnt == REP_W'(REPEAT_DELAY - 1)));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (state != S_HELD || s != pat) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b1;
        end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a key-matrix model drives Sense from Drive,
// and expectations come from the key set (winning column/row) and timing bounds.
module tb_keypad_scanner;
    localparam int ROWS = 4, COLS = 4, CODE_W = 4, DEBOUNCE = 8, SCAN_DIV = 4;
    localparam int REP_DELAY = 50, REP_PERIOD = 20;

    logic              Clock = 1'b0;
    logic              Reset;
    logic [ROWS-1:0]   Sense;
    logic [COLS-1:0]   Drive;
    logic              press, KeyValid, Multi;
    logic [CODE_W-1:0] CodeOut;
    logic [ROWS-1:0][COLS-1:0] keys;  // keys[row][col] = 1 when pressed

    int n_cmp = 0, n_bad = 0;
    int kv_consec = 0;
    logic kv_prev = 1'b0;

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .CODE_W(CODE_W), .DEBOUNCE(DEBOUNCE), .SCAN_DIV(SCAN_DIV),
        .REPEAT_DELAY(REP_DELAY), .REPEAT_PERIOD(REP_PERIOD)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Sense(Sense), .Drive(Drive), .press(press),
        .KeyValid(KeyValid), .CodeOut(CodeOut), .Multi(Multi)
    );

    always #5 Clock = ~Clock;

    // Passive matrix: a row reads low when a pressed key sits on a column driven low
    always_comb begin
        Sense = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (keys[r][c] && !Drive[c]) Sense[r] = 1'b0;
    end

    always @(negedge Clock) begin
        if (KeyValid && kv_prev) kv_consec++;
        kv_prev = KeyValid;
    end

    function automatic void expect_key(input logic [ROWS-1:0][COLS-1:0] k,
                                       output int col, output int code, output bit multi);
        col = -1; code = 0; multi = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            int nrows = 0;
            int first = -1;
            if (col >= 0) break;
            for (int r = 0; r < ROWS; r++)
                if (k[r][c]) begin
                    nrows++;
                    if (first < 0) first = r;
                end
            if (nrows > 0) begin
                col = c; code = first * COLS + c; multi = (nrows > 1);
            end
        end
    endfunction

    function automatic bit is_repeat(input int t);
`ifdef KEY_REPEAT_EN
        return (t >= REP_DELAY) && ((t - REP_DELAY) % REP_PERIOD == 0);
`else
        return (t < 0);
`endif
    endfunction

    task automatic wait_kv(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge Clock);
            if (KeyValid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic count_kv(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            if (KeyValid) cnt++;
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        keys  = '0;
        repeat (3) @(negedge Clock);
        n_cmp++; if (press !== 1'b0) begin n_bad++; $display("FAIL reset_press: got %b want 0", press); end
        n_cmp++; if (KeyValid !== 1'b0) begin n_bad++; $display("FAIL reset_keyvalid: got %b want 0", KeyValid); end
        n_cmp++; if (CodeOut !== '0) begin n_bad++; $display("FAIL reset_code: got %0d want 0", CodeOut); end
        n_cmp++; if (Multi !== 1'b0) begin n_bad++; $display("FAIL reset_multi: got %b want 0", Multi); end
        n_cmp++; if (Drive !== '0) begin n_bad++; $display("FAIL reset_drive: got %b want 0", Drive); end
        Reset = 1'b0;
        repeat (10) @(negedge Clock);
        n_cmp++; if (Drive !== '0 || press !== 1'b0) begin
            n_bad++; $display("FAIL idle_after_reset: drive %b press %b want 0/0", Drive, press);
        end
    endtask

    // Press key set k, hold it hold_after cycles past the strobe, release and check the fall
    task automatic run_hold(input logic [ROWS-1:0][COLS-1:0] k, input int hold_after, input string tag);
        int col, code, lat, extra, want_extra;
        bit multi;
        expect_key(k, col, code, multi);
        keys = k;
        wait_kv(2 + 1 + (col + 1) * SCAN_DIV + DEBOUNCE, lat);
        n_cmp++; if (lat < 0) begin n_bad++; $display("FAIL %s_latency: no KeyValid within bound", tag); end
        count_kv(hold_after, extra);
        want_extra = 0;
        for (int t = 1; t <= hold_after; t++) if (is_repeat(t)) want_extra++;
        n_cmp++; if (extra != want_extra) begin n_bad++; $display("FAIL %s_kv_count: got %0d extra want %0d", tag, extra, want_extra); end
        n_cmp++; if (CodeOut !== CODE_W'(code)) begin n_bad++; $display("FAIL %s_code: got %0d want %0d", tag, CodeOut, code); end
        n_cmp++; if (Multi !== multi) begin n_bad++; $display("FAIL %s_multi: got %b want %b", tag, Multi, multi); end
        n_cmp++; if (press !== 1'b1) begin n_bad++; $display("FAIL %s_press_held: got %b want 1", tag, press); end
        keys = '0;
        // two sync cycles then DEBOUNCE cycles of all-ones before press drops
        repeat (1 + DEBOUNCE) @(negedge Clock);
        n_cmp++; if (press !== 1'b1) begin n_bad++; $display("FAIL %s_press_early: got %b want 1", tag, press); end
        @(negedge Clock);
        n_cmp++; if (press !== 1'b0) begin n_bad++; $display("FAIL %s_press_fall: got %b want 0", tag, press); end
        n_cmp++; if (CodeOut !== CODE_W'(code) || Multi !== 1'b0) begin
            n_bad++; $display("FAIL %s_after_release: code %0d multi %b want %0d/0", tag, CodeOut, Multi, code);
        end
        repeat (20) @(negedge Clock);
    endtask

    task automatic test_single_key;
        logic [ROWS-1:0][COLS-1:0] k;
        k = '0; k[2][1] = 1'b1;
        run_hold(k, 82, "single");
    endtask

    task automatic test_glitch(input int r, input int c, input int len, input string tag);
        int n1, n2;
        keys = '0; keys[r][c] = 1'b1;
        count_kv(len, n1);
        keys = '0;
        count_kv(50, n2);
        n_cmp++; if (n1 + n2 != 0) begin n_bad++; $display("FAIL %s_kv: got %0d pulses want 0", tag, n1 + n2); end
        n_cmp++; if (Drive !== '0 || press !== 1'b0) begin
            n_bad++; $display("FAIL %s_idle: drive %b press %b want 0/0", tag, Drive, press);
        end
    endtask

    task automatic test_multi_key;
        logic [ROWS-1:0][COLS-1:0] k;
        k = '0; k[1][2] = 1'b1; k[3][2] = 1'b1;
        run_hold(k, 10, "multi_row");
        k = '0; k[2][0] = 1'b1; k[1][3] = 1'b1;
        run_hold(k, 10, "multi_col");
    endtask

    task automatic test_bounce;
        int lat, n;
        bit dropped;
        keys = '0; keys[1][1] = 1'b1;
        wait_kv(2 + 1 + 2 * SCAN_DIV + DEBOUNCE, lat);
        n_cmp++; if (lat < 0) begin n_bad++; $display("FAIL bounce_accept: no KeyValid within bound"); end
        repeat (10) @(negedge Clock);
        keys = '0;
        dropped = 1'b0; n = 0;
        repeat (3) @(negedge Clock);
        keys[1][1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (KeyValid) n++;
            if (!press) dropped = 1'b1;
        end
        n_cmp++; if (n != 0) begin n_bad++; $display("FAIL bounce_kv: got %0d pulses want 0", n); end
        n_cmp++; if (dropped) begin n_bad++; $display("FAIL bounce_press: press dropped, want held 1"); end
        keys = '0;
        repeat (30) @(negedge Clock);
    endtask

    task automatic test_reset_mid;
        int n, lat;
        logic [ROWS-1:0][COLS-1:0] k;
        keys = '0; keys[0][0] = 1'b1;
        count_kv(9, n);
        n_cmp++; if (n != 0) begin n_bad++; $display("FAIL rst_deb_early_kv: got %0d want 0", n); end
        Reset = 1'b1;
        #1;
        n_cmp++; if ({press, KeyValid, Multi} !== 3'b000 || CodeOut !== '0 || Drive !== '0) begin
            n_bad++; $display("FAIL rst_deb_outputs: press %b kv %b multi %b code %0d drive %b want all 0",
                              press, KeyValid, Multi, CodeOut, Drive);
        end
        keys = '0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (20) @(negedge Clock);
        n_cmp++; if (Drive !== '0 || press !== 1'b0) begin n_bad++; $display("FAIL rst_deb_idle: drive %b press %b", Drive, press); end
        k = '0; k[3][2] = 1'b1;
        run_hold(k, 5, "after_rst");
        keys = '0; keys[1][3] = 1'b1;
        wait_kv(2 + 1 + 4 * SCAN_DIV + DEBOUNCE, lat);
        n_cmp++; if (lat < 0) begin n_bad++; $display("FAIL rst_held_accept: no KeyValid within bound"); end
        repeat (5) @(negedge Clock);
        Reset = 1'b1;
        #1;
        n_cmp++; if ({press, KeyValid, Multi} !== 3'b000 || CodeOut !== '0 || Drive !== '0) begin
            n_bad++; $display("FAIL rst_held_outputs: press %b kv %b multi %b code %0d drive %b want all 0",
                              press, KeyValid, Multi, CodeOut, Drive);
        end
        keys = '0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (20) @(negedge Clock);
        n_cmp++; if (Drive !== '0 || press !== 1'b0) begin n_bad++; $display("FAIL rst_held_idle: drive %b press %b", Drive, press); end
    endtask

    task automatic test_repeat;
        int lat;
        int got[$], want[$];
        keys = '0; keys[0][0] = 1'b1;
        wait_kv(2 + 1 + SCAN_DIV + DEBOUNCE, lat);
        n_cmp++; if (lat < 0) begin n_bad++; $display("FAIL repeat_accept: no KeyValid within bound"); end
        for (int t = 1; t <= 120; t++) begin
            @(negedge Clock);
            if (KeyValid) got.push_back(t);
            if (is_repeat(t)) want.push_back(t);
        end
        n_cmp++; if (got.size() != want.size()) begin
            n_bad++; $display("FAIL repeat_count: got %0d repeats want %0d", got.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                n_cmp++; if (got[i] != want[i]) begin
                    n_bad++; $display("FAIL repeat_offset: got +%0d want +%0d", got[i], want[i]);
                end
            end
        end
        keys = '0;
        repeat (30) @(negedge Clock);
    endtask

    task automatic test_random;
        logic [ROWS-1:0][COLS-1:0] k;
        int mode, r0, r1, c0, c1;
        for (int trial = 0; trial < 16; trial++) begin
            mode = int'($urandom_range(0, 3));
            r0 = int'($urandom_range(0, ROWS - 1));
            c0 = int'($urandom_range(0, COLS - 1));
            k = '0; k[r0][c0] = 1'b1;
            if (mode == 1) begin
                r1 = (r0 + int'($urandom_range(1, ROWS - 1))) % ROWS;
                k[r1][c0] = 1'b1;
            end else if (mode == 2) begin
                r1 = int'($urandom_range(0, ROWS - 1));
                c1 = (c0 + int'($urandom_range(1, COLS - 1))) % COLS;
                k[r1][c1] = 1'b1;
            end
            if (mode == 3)
                test_glitch(r0, c0, int'($urandom_range(1, DEBOUNCE - 1)), "rand_glitch");
            else
                run_hold(k, int'($urandom_range(5, 40)), "rand_hold");
        end
    endtask

    initial begin
        keys  = '0;
        Reset = 1'b1;
        test_reset();
        test_single_key();
        test_glitch(0, 3, 5, "glitch");
        test_multi_key();
        test_bounce();
        test_reset_mid();
        test_repeat();
        test_random();
        n_cmp++; if (kv_consec != 0) begin n_bad++; $display("FAIL kv_consecutive: got %0d back-to-back pulses want 0", kv_consec); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end
endmodule
